// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter
//
// Shares one single-port pixel RAM between VGA scanout and CPU pixel writes.
// Scanout always wins the RAM slot. CPU writes are queued in a small FIFO and
// drained into the RAM on cycles when scanout does not need it.
//
// With FRAMEBUFFER_DOUBLE_BUFFER_EN defined, the RAM holds two banks:
// - Scanout reads the front bank.
// - CPU writes land in the back bank.
// - A swap request waits for the FIFO to drain. The banks are then exchanged
//   on the next falling edge of vsync.
// Without the macro, a single bank (bank 0) is used and the swap logic is
// absent.
//
// Ports:
//   clk                   single clock, all logic on posedge
//   i_Reset_N             synchronous active-low reset
//   i_Vga_Read_En         scanout needs the RAM slot this cycle
//   i_Vga_Read_Addr       scanout pixel address
//   o_Vga_Read_Data       pixel to scanout (pass-through of RAM read data)
//   i_Vertical_Sync       active-low vsync from scanout
//   i_Cpu_Wr_Valid        CPU write request
//   o_Cpu_Wr_Ready        CPU write accepted when high together with valid
//   i_Cpu_Wr_Addr         CPU write pixel address
//   i_Cpu_Wr_Data         CPU write pixel data
//   i_Swap_Req            one-cycle buffer-swap request
//   o_Swap_Pending        swap in progress
//   o_Front_Buffer        bank currently scanned out
//   o_Ram_Addr            RAM address, MSB is the bank select
//   o_Ram_Wr_En           RAM write enable
//   o_Ram_Wr_Data         RAM write data
//   i_Ram_Read_Data       RAM read data (1-cycle latency)

module framebuffer_arbiter #(
    parameter int unsigned BITS_PER_PIXEL    = 3,
    parameter int unsigned FRAMEBUFFER_DEPTH = 640 * 480,
    parameter int unsigned FIFO_DEPTH        = 4,
    localparam int unsigned ADDR_W           = $clog2(FRAMEBUFFER_DEPTH)
) (
    input  logic                      clk,
    input  logic                      i_Reset_N,
    input  logic                      i_Vga_Read_En,
    input  logic [ADDR_W-1:0]         i_Vga_Read_Addr,
    output logic [BITS_PER_PIXEL-1:0] o_Vga_Read_Data,
    input  logic                      i_Vertical_Sync,
    input  logic                      i_Cpu_Wr_Valid,
    output logic                      o_Cpu_Wr_Ready,
    input  logic [ADDR_W-1:0]         i_Cpu_Wr_Addr,
    input  logic [BITS_PER_PIXEL-1:0] i_Cpu_Wr_Data,
    input  logic                      i_Swap_Req,
    output logic                      o_Swap_Pending,
    output logic                      o_Front_Buffer,
    output logic [ADDR_W:0]           o_Ram_Addr,
    output logic                      o_Ram_Wr_En,
    output logic [BITS_PER_PIXEL-1:0] o_Ram_Wr_Data,
    input  logic [BITS_PER_PIXEL-1:0] i_Ram_Read_Data
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = FIFO_DEPTH[PTR_W:0];

    // ------------------------------------------------------------------
    // CPU write FIFO
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]         fifo_addr [FIFO_DEPTH];
    logic [BITS_PER_PIXEL-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [PTR_W:0]            count_q;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic                      front_buffer;
    logic                      write_bank;

    assign fifo_full  = (count_q == FULL_COUNT);
    assign fifo_empty = (count_q == '0);

    assign push = i_Cpu_Wr_Valid && o_Cpu_Wr_Ready;
    // Pop decision uses the registered count, so a write pushed into an empty
    // FIFO reaches the RAM one cycle later at the earliest.
    assign pop  = !i_Vga_Read_En && !fifo_empty && i_Reset_N;

    always_ff @(posedge clk) begin
        if (!i_Reset_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= i_Cpu_Wr_Addr;
            fifo_data[wr_ptr_q] <= i_Cpu_Wr_Data;
        end
    end

`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
    // ------------------------------------------------------------------
    // Buffer swap FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        StIdle,
        StWaitDrain,
        StWaitVblank
    } swap_state_e;

    swap_state_e state_q;
    logic        front_q;
    logic        pending_q;
    logic        vsync_q;

    always_ff @(posedge clk) begin
        if (!i_Reset_N) begin
            state_q   <= StIdle;
            front_q   <= 1'b0;
            pending_q <= 1'b0;
            vsync_q   <= 1'b1;
        end else begin
            vsync_q <= i_Vertical_Sync;
            unique case (state_q)
                StIdle: begin
                    if (i_Swap_Req) begin
                        state_q   <= StWaitDrain;
                        pending_q <= 1'b1;
                    end
                end
                StWaitDrain: begin
                    if (fifo_empty) begin
                        state_q <= StWaitVblank;
                    end
                end
                StWaitVblank: begin
                    // Falling edge of vsync marks the start of vertical blanking.
                    if (vsync_q && !i_Vertical_Sync) begin
                        front_q   <= ~front_q;
                        pending_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign front_buffer   = front_q;
    assign write_bank     = ~front_q;
    assign o_Swap_Pending = pending_q;
    // New writes are held off during a swap so the drain terminates.
    assign o_Cpu_Wr_Ready = !fifo_full && (state_q == StIdle) && i_Reset_N;
`else
    logic unused_swap_inputs;
    assign unused_swap_inputs = i_Swap_Req ^ i_Vertical_Sync;

    assign front_buffer   = 1'b0;
    assign write_bank     = 1'b0;
    assign o_Swap_Pending = 1'b0;
    assign o_Cpu_Wr_Ready = !fifo_full && i_Reset_N;
`endif

    assign o_Front_Buffer = front_buffer;

    // ------------------------------------------------------------------
    // RAM port mux: scanout has priority, otherwise drain one FIFO entry
    // ------------------------------------------------------------------
    always_comb begin
        o_Ram_Wr_En   = 1'b0;
        o_Ram_Wr_Data = fifo_data[rd_ptr_q];
        o_Ram_Addr    = {front_buffer, i_Vga_Read_Addr};
        if (pop) begin
            o_Ram_Wr_En = 1'b1;
            o_Ram_Addr  = {write_bank, fifo_addr[rd_ptr_q]};
        end
    end

    assign o_Vga_Read_Data = i_Ram_Read_Data;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb_framebuffer_arbiter
//
// Directed bench for framebuffer_arbiter.
// - A table of per-cycle vectors covers the RAM arbitration and the write FIFO.
// - Hand-written sequences cover the swap FSM and reset behaviour.
// Expectations follow whichever build is compiled (FRAMEBUFFER_DOUBLE_BUFFER_EN).
// Inputs change on the falling clock edge. Outputs are compared 1 ns later,
// well away from the rising edge.

module tb_framebuffer_arbiter;

    localparam int BPP   = 3;
    localparam int DEPTH = 16;
    localparam int FD    = 4;
    localparam int AW    = 4;
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
    localparam int WB = 1;   // bank written by the CPU while front = 0
`else
    localparam int WB = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           vga_en;
    logic [AW-1:0]  vga_addr;
    logic [BPP-1:0] vga_data;
    logic           vsync;
    logic           wr_valid;
    logic           wr_ready;
    logic [AW-1:0]  wr_addr;
    logic [BPP-1:0] wr_data;
    logic           swap_req;
    logic           swap_pending;
    logic           front;
    logic [AW:0]    ram_addr;
    logic           ram_wr_en;
    logic [BPP-1:0] ram_wr_data;
    logic [BPP-1:0] ram_rd;

    int checks   = 0;
    int failures = 0;

    framebuffer_arbiter #(
        .BITS_PER_PIXEL   (BPP),
        .FRAMEBUFFER_DEPTH(DEPTH),
        .FIFO_DEPTH       (FD)
    ) dut (
        .clk            (clk),
        .i_Reset_N      (rst_n),
        .i_Vga_Read_En  (vga_en),
        .i_Vga_Read_Addr(vga_addr),
        .o_Vga_Read_Data(vga_data),
        .i_Vertical_Sync(vsync),
        .i_Cpu_Wr_Valid (wr_valid),
        .o_Cpu_Wr_Ready (wr_ready),
        .i_Cpu_Wr_Addr  (wr_addr),
        .i_Cpu_Wr_Data  (wr_data),
        .i_Swap_Req     (swap_req),
        .o_Swap_Pending (swap_pending),
        .o_Front_Buffer (front),
        .o_Ram_Addr     (ram_addr),
        .o_Ram_Wr_En    (ram_wr_en),
        .o_Ram_Wr_Data  (ram_wr_data),
        .i_Ram_Read_Data(ram_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           ve;
        logic [AW-1:0]  va;
        logic [BPP-1:0] rd;
        logic           wv;
        logic [AW-1:0]  wa;
        logic [BPP-1:0] wd;
        logic           er;
        logic           ew;
        logic [AW:0]    ea;
        logic [BPP-1:0] ed;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input int ve, input int va, input int rd, input int wv, input int wa,
                       input int wd, input int er, input int ew, input int eb, input int ea,
                       input int ed);
        vec_t t;
        t.ve = ve[0];
        t.va = va[AW-1:0];
        t.rd = rd[BPP-1:0];
        t.wv = wv[0];
        t.wa = wa[AW-1:0];
        t.wd = wd[BPP-1:0];
        t.er = er[0];
        t.ew = ew[0];
        t.ea = {eb[0], ea[AW-1:0]};
        t.ed = ed[BPP-1:0];
        tbl.push_back(t);
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        vga_en   = 1'b0;
        vga_addr = '0;
        vsync    = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        swap_req = 1'b0;
        ram_rd   = '0;

        // Vectors start right after reset: front = 0, FIFO empty.
        //  ve va rd wv wa wd  er ew eb ea ed
        add(1, 3, 6, 0, 0, 0,  1, 0, 0, 3, 0);
        add(0, 7, 1, 1, 5, 5,  1, 0, 0, 7, 0);   // write addr 5 data 101
        add(0, 7, 2, 0, 0, 0,  1, 1, WB, 5, 5);  // lands one cycle later
        add(0, 7, 3, 0, 0, 0,  1, 0, 0, 7, 0);
        add(1, 1, 4, 1, 1, 1,  1, 0, 0, 1, 0);   // scanout busy, fill FIFO
        add(1, 1, 5, 1, 2, 2,  1, 0, 0, 1, 0);
        add(1, 1, 6, 1, 3, 3,  1, 0, 0, 1, 0);
        add(1, 1, 7, 1, 4, 4,  1, 0, 0, 1, 0);
        add(1, 1, 0, 1, 9, 7,  0, 0, 0, 1, 0);   // 5th write refused
        add(0, 1, 1, 0, 0, 0,  0, 1, WB, 1, 1);  // full: ready stays low on pop
        add(0, 1, 2, 1, 10, 6, 1, 1, WB, 2, 2);  // push + pop
        add(0, 1, 3, 0, 0, 0,  1, 1, WB, 3, 3);
        add(0, 1, 4, 1, 11, 1, 1, 1, WB, 4, 4);  // push + pop at count 2
        add(1, 2, 1, 0, 0, 0,  1, 0, 0, 2, 0);
        add(0, 2, 2, 0, 0, 0,  1, 1, WB, 10, 6);
        add(0, 2, 3, 0, 0, 0,  1, 1, WB, 11, 1);
        add(0, 2, 5, 0, 0, 0,  1, 0, 0, 2, 0);   // drained

        // Reset state
        next_cycle();
        chk("rst ready", wr_ready, 0);
        chk("rst wr_en", ram_wr_en, 0);
        next_cycle();
        rst_n = 1'b1;
        #1;
        chk("rst front", front, 0);
        chk("rst pending", swap_pending, 0);
        chk("rst ready release", wr_ready, 1);
        next_cycle();

        // Table-driven vectors
        for (int i = 0; i < tbl.size(); i++) begin
            vga_en   = tbl[i].ve;
            vga_addr = tbl[i].va;
            ram_rd   = tbl[i].rd;
            wr_valid = tbl[i].wv;
            wr_addr  = tbl[i].wa;
            wr_data  = tbl[i].wd;
            #1;
            chk($sformatf("v%0d ready", i), wr_ready, tbl[i].er);
            chk($sformatf("v%0d wr_en", i), ram_wr_en, tbl[i].ew);
            chk($sformatf("v%0d addr", i), ram_addr, tbl[i].ea);
            chk($sformatf("v%0d vga_data", i), vga_data, tbl[i].rd);
            if (tbl[i].ew) chk($sformatf("v%0d wr_data", i), ram_wr_data, tbl[i].ed);
            next_cycle();
        end
        wr_valid = 1'b0;

`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
        // Swap with two queued writes
        vga_en = 1'b1; vga_addr = 4'd3;
        wr_valid = 1'b1; wr_addr = 4'd6; wr_data = 3'd2;
        next_cycle();
        wr_addr = 4'd7; wr_data = 3'd3;
        next_cycle();
        wr_valid = 1'b0; swap_req = 1'b1;
        #1 chk("A pending before", swap_pending, 0);
        next_cycle();
        swap_req = 1'b0; wr_valid = 1'b1; wr_addr = 4'd12; wr_data = 3'd7;
        #1;
        chk("A pending", swap_pending, 1);
        chk("A ready low", wr_ready, 0);
        chk("A no write", ram_wr_en, 0);
        next_cycle();
        wr_valid = 1'b0; vga_en = 1'b0;
        #1;
        chk("A wr1 en", ram_wr_en, 1);
        chk("A wr1 addr", ram_addr, {1'b1, 4'd6});
        chk("A wr1 data", ram_wr_data, 3'd2);
        next_cycle();
        #1;
        chk("A wr2 en", ram_wr_en, 1);
        chk("A wr2 addr", ram_addr, {1'b1, 4'd7});
        chk("A wr2 data", ram_wr_data, 3'd3);
        next_cycle();
        #1;
        chk("A drained", ram_wr_en, 0);
        chk("A pending2", swap_pending, 1);
        next_cycle();
        vsync = 1'b0;
        #1;
        chk("A front before edge", front, 0);
        chk("A pending vblank", swap_pending, 1);
        next_cycle();
        vsync = 1'b1; vga_en = 1'b1;
        #1;
        chk("A front toggled", front, 1);
        chk("A pending clear", swap_pending, 0);
        chk("A ready back", wr_ready, 1);
        chk("A read bank", ram_addr, {1'b1, 4'd3});
        next_cycle();

        // vsync edge during drain is ignored
        wr_valid = 1'b1; wr_addr = 4'd8; wr_data = 3'd4;
        next_cycle();
        wr_valid = 1'b0; swap_req = 1'b1;
        next_cycle();
        swap_req = 1'b0; vsync = 1'b0;
        #1 chk("B pending", swap_pending, 1);
        next_cycle();
        vsync = 1'b1; vga_en = 1'b0;
        #1;
        chk("B wr addr", ram_addr, {1'b0, 4'd8});
        chk("B wr data", ram_wr_data, 3'd4);
        next_cycle();
        #1;
        chk("B no toggle", front, 1);
        chk("B still pending", swap_pending, 1);
        next_cycle();
        #1 chk("B front vblank", front, 1);
        next_cycle();
        vsync = 1'b0;
        next_cycle();
        vsync = 1'b1;
        #1;
        chk("B front toggled", front, 0);
        chk("B pending clear", swap_pending, 0);
        next_cycle();

        // Reset while waiting for vblank clears the front buffer
        vga_en = 1'b1; swap_req = 1'b1;
        next_cycle();
        swap_req = 1'b0;
        next_cycle();
        vsync = 1'b0;
        next_cycle();
        vsync = 1'b1;
        #1 chk("C front set", front, 1);
        swap_req = 1'b1;
        next_cycle();
        swap_req = 1'b0;
        next_cycle();
        rst_n = 1'b0;
        #1 chk("C rst ready", wr_ready, 0);
        next_cycle();
        rst_n = 1'b1;
        #1;
        chk("C front reset", front, 0);
        chk("C pending reset", swap_pending, 0);
        next_cycle();
`else
        // Swap request and vsync edge have no effect
        swap_req = 1'b1;
        next_cycle();
        swap_req = 1'b0; vsync = 1'b0;
        #1 chk("S pending", swap_pending, 0);
        next_cycle();
        vsync = 1'b1; vga_en = 1'b0; vga_addr = 4'd9;
        #1;
        chk("S front", front, 0);
        chk("S ready", wr_ready, 1);
        chk("S addr", ram_addr, {1'b0, 4'd9});
        next_cycle();
`endif

        // Reset with queued writes (mid-swap in the double-buffered build)
        vga_en = 1'b1; vga_addr = 4'd5;
        wr_valid = 1'b1; wr_addr = 4'd13; wr_data = 3'd3;
        next_cycle();
        wr_addr = 4'd14; wr_data = 3'd4;
        next_cycle();
        wr_valid = 1'b0; swap_req = 1'b1;
        next_cycle();
        swap_req = 1'b0; rst_n = 1'b0; vga_en = 1'b0;
        #1;
        chk("D pending pre-rst", swap_pending, WB);
        chk("D rst wr_en", ram_wr_en, 0);
        chk("D rst ready", wr_ready, 0);
        next_cycle();
        rst_n = 1'b1;
        #1;
        chk("D wr_en after", ram_wr_en, 0);
        chk("D pending", swap_pending, 0);
        chk("D front", front, 0);
        chk("D ready", wr_ready, 1);
        next_cycle();
        #1;
        chk("D still empty", ram_wr_en, 0);
        chk("D addr", ram_addr, {1'b0, 4'd5});
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
